// File: rtl/ca_pkg.sv
// Shared constants and FSM state type for the execute-stage multiply unit.
package ca_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 5;

  localparam logic [9:0] FUNCT_MUL = 10'b0000001000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;
endpackage

// File: rtl/mul_shift_add.sv
// Radix-2 shift-add multiply datapath: one conditional add and shift per step.
module mul_shift_add
  import ca_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] mcand_i,
  input  logic [XLEN-1:0] mplier_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] acc_next_o
);

  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] addend;

  // Sum after the current step; the top samples this on the final iteration.
  assign addend     = mplier_q[0] ? mcand_q : '0;
  assign acc_next_o = acc_q + addend;
  assign acc_o      = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_next_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/ex_mul_unit.sv
// Multi-cycle MUL unit for the EX stage: stalls the front end for 32 iterations
// and presents the low product word with a one-cycle done strobe.
module ex_mul_unit
  import ca_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [9:0]            funct_i,
  input  logic [XLEN-1:0]       RS1data_i,
  input  logic [XLEN-1:0]       RS2data_i,
  input  logic [REG_ADDR_W-1:0] RDaddr_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] RDaddr_o
);

  mul_state_e            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [REG_ADDR_W-1:0] rd_cap_q, rd_cap_d;
  logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  req;
  logic                  load;
  logic                  step;
  logic [XLEN-1:0]       acc;
  logic [XLEN-1:0]       acc_next;

  assign req = valid_i && (funct_i == FUNCT_MUL);

  mul_shift_add u_dp (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .step_i     (step),
    .mcand_i    (RS1data_i),
    .mplier_i   (RS2data_i),
    .acc_o      (acc),
    .acc_next_o (acc_next)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_cap_d = rd_cap_q;
    rd_out_d = rd_out_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Flush wins over a coincident request; stall only for an acceptable MUL.
        stall_o = req && !flush_i;
        if (req && start_i && !flush_i) begin
          load     = 1'b1;
          rd_cap_d = RDaddr_i;
          count_d  = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (start_i) begin
          step    = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(XLEN - 1)) begin
            result_d = acc_next;
            rd_out_d = rd_cap_q;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_o = !flush_i;
        if (flush_i || start_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rd_cap_q <= '0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_cap_q <= rd_cap_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;
  assign RDaddr_o = rd_out_q;

endmodule

// File: tb/tb_ex_mul_unit.sv
// Scoreboard bench for ex_mul_unit: stimulus queues expected results, a monitor
// checks each done strobe for value, destination and cycle.
module tb_ex_mul_unit;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [9:0]  funct_i = 10'b0;
  logic [31:0] RS1data_i = '0;
  logic [31:0] RS2data_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  RDaddr_o;

  localparam logic [9:0] F_MUL = 10'b0000001000;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] last_res = '0;

  ex_mul_unit dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .funct_i   (funct_i),
    .RS1data_i (RS1data_i),
    .RS2data_i (RS2data_i),
    .RDaddr_i  (RDaddr_i),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .RDaddr_o  (RDaddr_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done strobe must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("done: result=%h rd=%0d cycle=%0d (expected %h rd=%0d cycle=%0d)",
                 result_o, RDaddr_o, cyc, e.res, e.rd, e.cyc);
        chk("result", result_o, e.res);
        chk("rdaddr", 32'(RDaddr_o), 32'(e.rd));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Issue a MUL and track stall_o; start_i is dropped for hold_len cycles from hold_from.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int hold_from, input int hold_len);
    int   c0;
    int   total;
    exp_t e;
    c0    = cyc;
    total = 33 + hold_len;
    valid_i = 1'b1; funct_i = F_MUL; RS1data_i = a; RS2data_i = b; RDaddr_i = rd;
    e.res = exp_res; e.rd = rd; e.cyc = c0 + total;
    sb_q.push_back(e);
    $display("issue: %h * %h rd=%0d at cycle %0d", a, b, rd, c0);
    for (int rel = 0; rel < total; rel++) begin
      start_i = !(hold_len > 0 && rel >= hold_from && rel < hold_from + hold_len);
      @(negedge clk_i);
      chk("stall_busy", 32'(stall_o), 32'd1);
      next_cycle();
    end
    start_i = 1'b1;
    @(negedge clk_i);
    chk("stall_done", 32'(stall_o), 32'd0);
    next_cycle();
    valid_i = 1'b0;
    last_res = exp_res;
  endtask

  initial begin
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rdaddr", 32'(RDaddr_o), 32'd0);
    next_cycle();
    rst_i = 1'b1;
    next_cycle();

    run_mul(32'd7, 32'd6, 5'd5, 32'd42, 0, 0);
    chk("hold_result", result_o, 32'd42);
    run_mul(32'hFFFF_FFFF, 32'd2, 5'd9, 32'hFFFF_FFFE, 0, 0);
    run_mul(32'h8000_0000, 32'h8000_0000, 5'd31, 32'd0, 0, 0);
    run_mul(32'd3, 32'd3, 5'd4, 32'd9, 10, 5);

    // Non-MUL instruction never stalls nor completes.
    valid_i = 1'b1; funct_i = 10'b0; RS1data_i = 32'd11; RS2data_i = 32'd12;
    $display("issue: ADD for 40 cycles");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      chk("add_stall", 32'(stall_o), 32'd0);
      chk("add_done", 32'(done_o), 32'd0);
      next_cycle();
    end
    valid_i = 1'b0;

    // Flush in cycle 10 aborts silently.
    valid_i = 1'b1; funct_i = F_MUL; RS1data_i = 32'd9; RS2data_i = 32'd9; RDaddr_i = 5'd3;
    $display("issue: 9*9 with flush at cycle 10");
    for (int rel = 0; rel < 10; rel++) next_cycle();
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_stall_cyc10", 32'(stall_o), 32'd1);
    next_cycle();
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush_stall_cyc11", 32'(stall_o), 32'd0);
    chk("flush_result", result_o, last_res);
    for (int i = 0; i < 40; i++) next_cycle();
    chk("flush_result_late", result_o, last_res);

    // Reset mid-operation in cycle 15.
    valid_i = 1'b1; funct_i = F_MUL; RS1data_i = 32'd5; RS2data_i = 32'd5; RDaddr_i = 5'd7;
    $display("issue: 5*5 with reset at cycle 15");
    for (int rel = 0; rel < 15; rel++) next_cycle();
    rst_i = 1'b0; valid_i = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_result", result_o, 32'd0);
    chk("mid_rst_rdaddr", 32'(RDaddr_o), 32'd0);
    next_cycle();
    next_cycle();
    rst_i = 1'b1;
    for (int i = 0; i < 40; i++) next_cycle();
    run_mul(32'd2, 32'd4, 5'd1, 32'd8, 0, 0);

    for (int i = 0; i < 3; i++) next_cycle();
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
